// File: rtl/mode_selector_pkg.sv
// Shared definitions for the push-button mode selector: button indices,
// repeat FSM state encoding and the mode register width helper.
package mode_selector_pkg;

    localparam int BTN_UP = 0;
    localparam int BTN_DN = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Width of a register able to hold 0 .. n-1, never narrower than one bit.
    function automatic int mode_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/mode_selector_if.sv
// Bundle of the board-facing button pins and the mode outputs.
// master = environment (drives buttons), slave = mode_selector.
interface mode_selector_if
    import mode_selector_pkg::*;
#(
    parameter int NUM_MODES = 4
);
    localparam int MODE_W = mode_width(NUM_MODES);

    logic [1:0]           buttons_n;
    logic [MODE_W-1:0]    mode;
    logic [NUM_MODES-1:0] mode_onehot;
    logic                 mode_changed;
    logic [1:0]           btn_level;

    modport master (
        output buttons_n,
        input  mode,
        input  mode_onehot,
        input  mode_changed,
        input  btn_level
    );

    modport slave (
        input  buttons_n,
        output mode,
        output mode_onehot,
        output mode_changed,
        output btn_level
    );

endinterface

// File: rtl/mode_selector_button_debouncer.sv
// One push-button input path: inversion, 2-FF synchroniser, debounce
// counter, registered debounced level and a one-cycle press pulse.
// A button already held when reset releases is not "armed" and yields no
// press pulse until it has been seen released.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [1:0]       valid_r;
    logic             armed_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the inverted raw pin; valid_r marks when sync2_r holds a real sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            valid_r <= 2'b00;
        end else begin
            sync1_r <= ~btn_n;
            sync2_r <= sync1_r;
            valid_r <= {valid_r[0], 1'b1};
        end
    end

    // Debounce: restart on agreement, flip level after CNT_LAST+1 consecutive disagreements.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else if (sync2_r == level_r) begin
            cnt_r   <= '0;
            press_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            level_r <= sync2_r;
            press_r <= sync2_r & armed_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            press_r <= 1'b0;
        end
    end

    // Arm press detection once the button has been observed released after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed_r <= 1'b0;
        end else if (valid_r[1] && !sync2_r && !level_r) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/mode_selector.sv
// N-way mode register stepped by two debounced push-buttons, with
// hold-to-auto-repeat, wrap-around, home on simultaneous press and a
// one-cycle change strobe. All outputs are registered.
module mode_selector
    import mode_selector_pkg::*;
#(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 2000000,
    parameter int RESET_MODE      = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    mode_selector_if.slave  bus
);

    localparam int MODE_W  = mode_width(NUM_MODES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [RPT_W-1:0]     DELAY_LAST  = (REPEAT_DELAY > 0) ? RPT_W'(REPEAT_DELAY - 1) : '0;
    localparam logic [RPT_W-1:0]     PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [MODE_W-1:0]    MODE_LAST   = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0]    MODE_HOME   = MODE_W'(RESET_MODE);
    localparam logic [NUM_MODES-1:0] ONEHOT_ONE  = NUM_MODES'(1);

    logic [1:0]        level_s;
    logic [1:0]        press_s;
    logic              both_s;
    logic              home_s;
    logic [1:0]        rpt_ev_s;
    logic [1:0]        ev_s;

    rpt_state_t        state_r   [2];
    rpt_state_t        state_nxt [2];
    logic [RPT_W-1:0]  cnt_r     [2];
    logic [RPT_W-1:0]  cnt_nxt   [2];

    logic [MODE_W-1:0]    mode_r;
    logic [MODE_W-1:0]    mode_nxt;
    logic [NUM_MODES-1:0] onehot_r;
    logic                 changed_r;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clock   (clock),
        .reset_n (reset_n),
        .btn_n   (bus.buttons_n[BTN_UP]),
        .level   (level_s[BTN_UP]),
        .press   (press_s[BTN_UP])
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_dn (
        .clock   (clock),
        .reset_n (reset_n),
        .btn_n   (bus.buttons_n[BTN_DN]),
        .level   (level_s[BTN_DN]),
        .press   (press_s[BTN_DN])
    );

    assign both_s = level_s[BTN_UP] & level_s[BTN_DN];
    assign home_s = press_s[BTN_UP] & press_s[BTN_DN];
    assign ev_s   = press_s | rpt_ev_s;

    // Repeat FSM state and counter registers for both buttons.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                state_r[b] <= IDLE;
                cnt_r[b]   <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_r[b] <= state_nxt[b];
                cnt_r[b]   <= cnt_nxt[b];
            end
        end
    end

    // Repeat FSM next state: release or both-held forces IDLE; otherwise hold/repeat timing.
    always_comb begin
        rpt_ev_s = 2'b00;
        for (int b = 0; b < 2; b++) begin
            state_nxt[b] = state_r[b];
            cnt_nxt[b]   = cnt_r[b];
            if (!level_s[b] || both_s) begin
                state_nxt[b] = IDLE;
                cnt_nxt[b]   = '0;
            end else begin
                case (state_r[b])
                    IDLE: begin
                        if (press_s[b]) begin
                            state_nxt[b] = HOLD;
                            cnt_nxt[b]   = '0;
                        end else begin
                            state_nxt[b] = IDLE;
                        end
                    end
                    HOLD: begin
                        if (REPEAT_DELAY == 0) begin
                            cnt_nxt[b] = cnt_r[b];
                        end else if (cnt_r[b] == DELAY_LAST) begin
                            rpt_ev_s[b]  = 1'b1;
                            cnt_nxt[b]   = '0;
                            state_nxt[b] = REPEAT;
                        end else begin
                            cnt_nxt[b] = cnt_r[b] + RPT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (cnt_r[b] == PERIOD_LAST) begin
                            rpt_ev_s[b] = 1'b1;
                            cnt_nxt[b]  = '0;
                        end else begin
                            cnt_nxt[b] = cnt_r[b] + RPT_W'(1);
                        end
                    end
                    default: begin
                        state_nxt[b] = IDLE;
                        cnt_nxt[b]   = '0;
                    end
                endcase
            end
        end
    end

    // Resolve this cycle's step events into the next mode value.
    always_comb begin
        mode_nxt = mode_r;
        if (home_s) begin
            mode_nxt = MODE_HOME;
        end else if (both_s) begin
            mode_nxt = mode_r;
        end else if (ev_s[BTN_UP] && !ev_s[BTN_DN]) begin
            if (mode_r >= MODE_LAST) begin
                mode_nxt = '0;
            end else begin
                mode_nxt = mode_r + MODE_W'(1);
            end
        end else if (ev_s[BTN_DN] && !ev_s[BTN_UP]) begin
            if (mode_r == '0 || mode_r > MODE_LAST) begin
                mode_nxt = MODE_LAST;
            end else begin
                mode_nxt = mode_r - MODE_W'(1);
            end
        end else begin
            mode_nxt = mode_r;
        end
    end

    // Mode register with its one-hot decode and change strobe registered alongside.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_r    <= MODE_HOME;
            onehot_r  <= ONEHOT_ONE << RESET_MODE;
            changed_r <= 1'b0;
        end else begin
            mode_r    <= mode_nxt;
            onehot_r  <= ONEHOT_ONE << mode_nxt;
            changed_r <= (mode_nxt != mode_r);
        end
    end

    assign bus.mode         = mode_r;
    assign bus.mode_onehot  = onehot_r;
    assign bus.mode_changed = changed_r;
    assign bus.btn_level    = level_s;

endmodule

// File: tb/tb_mode_selector.sv
// Scoreboard bench for mode_selector: stimulus pushes the expected mode of
// every change into a queue; a negedge monitor pops on each mode_changed.
module tb_mode_selector;

    localparam int NM  = 5;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int RM  = 0;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    mode_selector_if #(.NUM_MODES(NM)) bus ();

    mode_selector #(
        .NUM_MODES       (NM),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .RESET_MODE      (RM)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int mon_exp;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Wait n rising edges, then step 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Hold the buttons in mask pressed for n raw cycles, then release and settle.
    task automatic press(input logic [1:0] mask, input int n);
        bus.buttons_n = ~mask;
        cyc(n);
        bus.buttons_n = 2'b11;
        cyc(12);
    endtask

    // Monitor: each change strobe must match the next expected mode.
    always @(negedge clock) begin
        if (bus.mode_changed === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got mode %0d expected no change", bus.mode);
            end else begin
                mon_exp = exp_q.pop_front();
                check("mode_seq", int'(bus.mode), mon_exp);
                check("onehot_seq", int'(bus.mode_onehot), 1 << mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.buttons_n = 2'b11;
        reset_n = 1'b0;
        cyc(3);
        check("rst_mode", int'(bus.mode), 0);
        check("rst_onehot", int'(bus.mode_onehot), 1);
        check("rst_changed", int'(bus.mode_changed), 0);
        check("rst_level", int'(bus.btn_level), 0);
        reset_n = 1'b1;
        cyc(5);

        // 2-cycle glitch on up: debounced level and mode must not move
        bus.buttons_n = 2'b10;
        cyc(2);
        bus.buttons_n = 2'b11;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check("glitch_level", int'(bus.btn_level), 0);
        end
        check("glitch_mode", int'(bus.mode), 0);

        // 20-cycle up press: level high in cycles 6..25 after the raw edge,
        // events at 6 (press) and 16,19,22,25 (repeat) -> 1,2,3,4,0
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(4); exp_q.push_back(0);
        bus.buttons_n = 2'b10;
        cyc(5);
        check("level_before", int'(bus.btn_level), 0);
        cyc(1);
        check("level_rise", int'(bus.btn_level), 1);
        cyc(1);
        check("press_mode", int'(bus.mode), 1);
        check("press_changed", int'(bus.mode_changed), 1);
        check("press_onehot", int'(bus.mode_onehot), 5'b00010);
        cyc(13);
        bus.buttons_n = 2'b11;
        cyc(12);
        check("long_press_mode", int'(bus.mode), 0);

        // five single up presses wrap 4 -> 0, then down wraps 0 -> 4, down again -> 3
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(4); exp_q.push_back(0);
        for (int i = 0; i < 5; i++) press(2'b01, 6);
        check("wrap_up", int'(bus.mode), 0);
        exp_q.push_back(4);
        press(2'b10, 6);
        check("wrap_dn", int'(bus.mode), 4);
        exp_q.push_back(3);
        press(2'b10, 6);
        check("dn_to_3", int'(bus.mode), 3);

        // hold down 40 cycles: press step + repeats at +10,+13,...,+37 -> 11 steps from 3
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(4); exp_q.push_back(3); exp_q.push_back(2);
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(4);
        exp_q.push_back(3); exp_q.push_back(2);
        press(2'b10, 40);
        check("hold_final", int'(bus.mode), 2);

        // both pressed together at 3 -> home, no steps while both held
        exp_q.push_back(3);
        press(2'b01, 6);
        check("up_to_3", int'(bus.mode), 3);
        exp_q.push_back(0);
        press(2'b11, 20);
        check("home_mode", int'(bus.mode), 0);
        press(2'b11, 20);
        check("home_again", int'(bus.mode), 0);

        // up held into REPEAT (events 6,16,19 -> 1,2,3), then async reset
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        bus.buttons_n = 2'b10;
        cyc(21);
        check("pre_reset_mode", int'(bus.mode), 3);
        reset_n = 1'b0;
        #1;
        check("async_mode", int'(bus.mode), 0);
        check("async_onehot", int'(bus.mode_onehot), 1);
        check("async_level", int'(bus.btn_level), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc(30);
        check("held_after_reset_mode", int'(bus.mode), 0);
        check("held_after_reset_level", int'(bus.btn_level), 1);
        bus.buttons_n = 2'b11;
        cyc(12);
        exp_q.push_back(1);
        press(2'b01, 6);
        check("fresh_press_mode", int'(bus.mode), 1);

        cyc(5);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
